chunked_serial_adder: RTL and testbench

Multi-cycle, parametrised-width add/subtract unit that processes a WIDTH-bit operand pair CHUNK bits per clock, rippling carry through a register between chunks. It generalises the lab ripple-carry full adder into an arbitrary-width, time-multiplexed datapath with add and subtract modes, signed-overflow detection, and valid/ready handshakes on input and output. It sits between an operand-issuing controller and a result consumer in the ALU path, where area matters more than single-cycle latency.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/chunk_adder.sv | 37 +++
 rtl/chunked_serial_adder.sv | 155 +++++++++++++++
 tb/tb_chunked_serial_adder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and helpers for the chunked serial adder
package adder_pkg;

    // Controller states: accept operands, add one chunk per cycle, hold result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int nchunk_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width; a single-chunk datapath still gets a 1-bit index.
    function automatic int idx_width_f(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational W-bit ripple adder built from full-adder cells
//
// Ports:
//   a_i, b_i    - W-bit addends
//   cin_i       - carry into bit 0
//   s_o         - W-bit sum
//   cout_o      - carry out of bit W-1
//   c_msb_in_o  - carry into bit W-1 (used for signed-overflow detection)
module chunk_adder
    import adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o,
    output logic         c_msb_in_o
);

    // carry_v[i] is the carry into bit i; carry_v[W] is the carry out.
    logic [W:0] carry_v;

    always_comb begin
        carry_v    = '0;
        s_o        = '0;
        carry_v[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            {carry_v[i+1], s_o[i]} = full_add(a_i[i], b_i[i], carry_v[i]);
        end
    end

    assign cout_o     = carry_v[W];
    assign c_msb_in_o = carry_v[W-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle add/subtract unit, CHUNK bits per clock
//
// Ports:
//   clock, reset_n       - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub       - operands; sub=1 computes a - b - cin
//   out_valid / out_ready- result handshake (out_valid high only in DONE)
//   s, cout, ovf         - result, carry-out (NOT-borrow when subtracting),
//                          two's-complement overflow
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int IDXW   = idx_width_f(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK > WIDTH) begin : g_param_check
            $error("chunked_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;       // b already inverted for subtraction
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  sum_chunk;
    logic              chunk_cout;
    logic              chunk_c_msb;

    // Select the operand slice addressed by the chunk index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .W (CHUNK)
    ) u_chunk_adder (
        .a_i        (a_chunk),
        .b_i        (b_chunk),
        .cin_i      (carry_q),
        .s_o        (sum_chunk),
        .cout_o     (chunk_cout),
        .c_msb_in_o (chunk_c_msb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction as a + ~b + 1; a borrow-in cancels that +1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        s_d[k*CHUNK +: CHUNK] = sum_chunk;
                    end
                end
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // The last chunk holds the MSB, so its carries give the flags.
                    cout_d  = chunk_cout;
                    ovf_d   = chunk_c_msb ^ chunk_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - scoreboard bench for chunked_serial_adder
module tb_chunked_serial_adder;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // Instance 0: 32/4
    logic        iv0, ir0, ov0, ordy0, cin0, sub0, co0, of0;
    logic [31:0] a0, b0, s0;
    // Instance 1: 2/1
    logic        iv1, ir1, ov1, cin1, sub1, co1, of1;
    logic [1:0]  a1, b1, s1;
    // Instance 2: 2/2
    logic        iv2, ir2, ov2, cin2, sub2, co2, of2;
    logic [1:0]  a2, b2, s2;

    chunked_serial_adder #(.WIDTH(32), .CHUNK(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(ordy0),
        .s(s0), .cout(co0), .ovf(of0));

    chunked_serial_adder #(.WIDTH(2), .CHUNK(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(1'b1),
        .s(s1), .cout(co1), .ovf(of1));

    chunked_serial_adder #(.WIDTH(2), .CHUNK(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(1'b1),
        .s(s2), .cout(co2), .ovf(of2));

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        longint      acc;
        int          lat;
    } exp_t;

    exp_t   exp_q[3][$];
    exp_t   cur[3];
    logic   prev[3];
    logic   has_cur[3];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    logic   bp_rand = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit unsigned/signed values.
    function automatic exp_t model(input int w, input longint av, input longint bv,
                                   input int cv, input int sv);
        exp_t   e;
        longint m, sa, sb, u, sig;
        m  = longint'(1) << w;
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        if (sv == 0) begin
            u      = av + bv + cv;
            e.cout = (u >= m);
            sig    = sa + sb + cv;
        end else begin
            u      = av - bv - cv;
            e.cout = (u >= 0);
            sig    = sa - sb - cv;
            u      = u + m;
        end
        e.s   = 32'(u % m);
        e.ovf = (sig < -(m / 2)) || (sig > (m / 2 - 1));
        e.acc = 0;
        e.lat = 0;
        return e;
    endfunction

    task automatic mon_step(input int id, input logic ov, input logic [31:0] sv,
                            input logic co, input logic of);
        if (!reset_n) begin
            prev[id]    = 1'b0;
            has_cur[id] = 1'b0;
            return;
        end
        if (ov && !prev[id]) begin
            if (exp_q[id].size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut%0d_unexpected_result: out_valid rose with s=%0h, expected no result", id, sv);
            end else begin
                cur[id]     = exp_q[id].pop_front();
                has_cur[id] = 1'b1;
                check($sformatf("dut%0d_latency", id), 64'(cyc - cur[id].acc), 64'(cur[id].lat));
                check($sformatf("dut%0d_s", id), 64'(sv), 64'(cur[id].s));
                check($sformatf("dut%0d_cout", id), 64'(co), 64'(cur[id].cout));
                check($sformatf("dut%0d_ovf", id), 64'(of), 64'(cur[id].ovf));
            end
        end else if (ov && has_cur[id]) begin
            check($sformatf("dut%0d_hold_s", id), 64'(sv), 64'(cur[id].s));
            check($sformatf("dut%0d_hold_cout", id), 64'(co), 64'(cur[id].cout));
            check($sformatf("dut%0d_hold_ovf", id), 64'(of), 64'(cur[id].ovf));
        end
        prev[id] = ov;
    endtask

    initial forever begin @(negedge clock); mon_step(0, ov0, s0, co0, of0); end
    initial forever begin @(negedge clock); mon_step(1, ov1, 32'(s1), co1, of1); end
    initial forever begin @(negedge clock); mon_step(2, ov2, 32'(s2), co2, of2); end

    initial forever begin
        @(negedge clock);
        if (bp_rand) ordy0 = ($urandom_range(0, 3) != 0);
    end

    // Called just after a falling edge; returns one falling edge after the accept.
    task automatic issue0(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
        exp_t e;
        int   t;
        a0 = av; b0 = bv; cin0 = cv; sub0 = sv; iv0 = 1'b1;
        t = 0;
        while (!ir0 && t < 500) begin @(negedge clock); t++; end
        if (!ir0) begin
            n_cmp++; n_bad++;
            $display("FAIL dut0_accept_timeout: in_ready=%0b expected 1", ir0);
            iv0 = 1'b0;
            return;
        end
        e = model(32, longint'(av), longint'(bv), int'(cv), int'(sv));
        e.lat = 8;
        e.acc = cyc + 1;
        exp_q[0].push_back(e);
        @(negedge clock);
        iv0 = 1'b0;
        a0 = $urandom; b0 = $urandom; cin0 = $urandom_range(0, 1); sub0 = $urandom_range(0, 1);
    endtask

    task automatic issue_small(input int id, input logic [1:0] av, input logic [1:0] bv,
                               input logic cv, input logic sv);
        exp_t e;
        int   t;
        if (id == 1) begin a1 = av; b1 = bv; cin1 = cv; sub1 = sv; iv1 = 1'b1; end
        else         begin a2 = av; b2 = bv; cin2 = cv; sub2 = sv; iv2 = 1'b1; end
        t = 0;
        while (!(id == 1 ? ir1 : ir2) && t < 100) begin @(negedge clock); t++; end
        if (!(id == 1 ? ir1 : ir2)) begin
            n_cmp++; n_bad++;
            $display("FAIL dut%0d_accept_timeout: in_ready=0 expected 1", id);
        end else begin
            e = model(2, longint'(av), longint'(bv), int'(cv), int'(sv));
            e.lat = (id == 1) ? 2 : 1;
            e.acc = cyc + 1;
            exp_q[id].push_back(e);
            @(negedge clock);
        end
        iv1 = 1'b0;
        iv2 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0
                || ov0 || ov1 || ov2) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: pending=%0d/%0d/%0d expected 0",
                     exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    logic [31:0] dir_a [7] = '{32'h5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h7, 32'h80000000, 32'h10};
    logic [31:0] dir_b [7] = '{32'h3, 32'h1, 32'h1, 32'h7, 32'h5, 32'h1, 32'h3};
    logic        dir_c [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        dir_s [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] edge_v [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    initial begin
        exp_t        tmp;
        logic [5:0]  v;
        logic [31:0] ra, rb;
        int          t;

        reset_n = 1'b0;
        iv0 = 0; iv1 = 0; iv2 = 0; ordy0 = 1'b1;
        a0 = 0; b0 = 0; cin0 = 0; sub0 = 0;
        a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
        a2 = 0; b2 = 0; cin2 = 0; sub2 = 0;
        repeat (3) @(negedge clock);
        check("reset_in_ready", 64'(ir0), 64'd1);
        check("reset_out_valid", 64'(ov0), 64'd0);
        check("reset_s", 64'(s0), 64'd0);
        check("reset_cout", 64'(co0), 64'd0);
        check("reset_ovf", 64'(of0), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_in_ready", 64'(ir0), 64'd1);

        for (int i = 0; i < 7; i++) issue0(dir_a[i], dir_b[i], dir_c[i], dir_s[i]);
        drain();

        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            issue0(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        bp_rand = 1'b0;
        ordy0 = 1'b1;
        drain();

        // Backpressure with in_valid held high throughout DONE.
        ordy0 = 1'b0;
        issue0(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0);
        a0 = 32'hA5A5A5A5; b0 = 32'h5A5A5A5A; cin0 = 1'b1; sub0 = 1'b0; iv0 = 1'b1;
        t = 0;
        while (!ov0 && t < 50) begin @(negedge clock); t++; end
        check("bp_reached_done", 64'(ov0), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_in_ready", 64'(ir0), 64'd0);
            check("bp_out_valid", 64'(ov0), 64'd1);
        end
        ordy0 = 1'b1;
        @(negedge clock);
        check("bp_release_in_ready", 64'(ir0), 64'd1);
        check("bp_release_out_valid", 64'(ov0), 64'd0);
        issue0(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0);
        drain();

        // Reset after the 3rd RUN edge abandons the operation.
        issue0(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(ir0), 64'd1);
        check("midrst_out_valid", 64'(ov0), 64'd0);
        check("midrst_s", 64'(s0), 64'd0);
        tmp = exp_q[0].pop_back();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        check("midrst_no_result", 64'(ov0), 64'd0);
        issue0(32'h1, 32'h1, 1'b0, 1'b0);
        drain();

        // Exhaustive 2-bit configurations.
        for (int id = 1; id <= 2; id++) begin
            for (int i = 0; i < 64; i++) begin
                v = i[5:0];
                issue_small(id, v[3:2], v[1:0], v[4], v[5]);
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
